// File: rtl/sram_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_loader_pkg
// Brief    : Shared types and constants for the SRAM program loader/player.
// Revision : 1.0 - initial release
// ============================================================================
package sram_loader_pkg;

    localparam int c_ADDR_W = 18;
    localparam logic [c_ADDR_W-1:0] c_ADDR_MAX = '1;

    // Instruction word layout: note in the low nibble, octave just above it.
    localparam int c_NOTE_LSB = 0;
    localparam int c_NOTE_W   = 4;
    localparam int c_OCT_LSB  = 4;
    localparam int c_OCT_W    = 2;

    typedef logic [c_ADDR_W-1:0] sram_addr_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        PULSE    = 3'd2,
        HOLD     = 3'd3,
        FINISHED = 3'd4
    } loader_state_t;

    function automatic logic [c_NOTE_W-1:0] instr_note(input logic [15:0] word);
        return word[c_NOTE_LSB +: c_NOTE_W];
    endfunction

    function automatic logic [c_OCT_W-1:0] instr_octave(input logic [15:0] word);
        return word[c_OCT_LSB +: c_OCT_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_loader_write_timer.sv
`default_nettype none
// ============================================================================
// Module   : sram_write_timer
// Brief    : Down-counter timing the SRAM write-enable low pulse.
// Revision : 1.0 - initial release
// ============================================================================
module sram_write_timer #(
    parameter int WE_CYCLES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_load,
    output logic o_expired
);

    localparam logic [3:0] c_LOAD_VAL = 4'(WE_CYCLES - 1);

    logic [3:0] r_cnt;

    // Loaded on the edge that enters the pulse; expired marks its final cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= 4'd0;
        end else if (i_load) begin
            r_cnt <= c_LOAD_VAL;
        end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_expired = (r_cnt == 4'd0);

endmodule
`default_nettype wire

// File: rtl/sram_loader.sv
`default_nettype none
// ============================================================================
// Module   : sram_loader
// Brief    : Streams instruction words into an asynchronous SRAM, one word
//            per SETUP/PULSE/HOLD write cycle, with sticky DONE/OVERFLOW.
// Revision : 1.0 - initial release
// ============================================================================
module sram_loader
    import sram_loader_pkg::*;
#(
    parameter logic [c_ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                  WE_CYCLES = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                IN_VALID,
    output logic                IN_READY,
    input  logic [15:0]         IN_DATA,
    input  logic                IN_LAST,
    output logic [c_ADDR_W-1:0] SRAM_A,
    output logic [15:0]         SRAM_DQ_OUT,
    output logic                SRAM_DQ_EN,
    output logic                SRAM_WE,
    output logic                SRAM_CE,
    output logic                SRAM_OE,
    output logic                SRAM_LB,
    output logic                SRAM_UB,
    output logic                BUSY,
    output logic                DONE,
    output logic                OVERFLOW,
    output logic [c_ADDR_W-1:0] WORD_COUNT
);

    loader_state_t r_state;
    sram_addr_t    r_addr;
    sram_addr_t    r_word_count;
    logic [15:0]   r_dq_out;
    logic          r_last;
    logic          r_dq_en;
    logic          r_we;
    logic          r_done;
    logic          r_overflow;

    logic w_in_ready;
    logic w_accept;
    logic w_pulse_done;

    assign w_in_ready = (r_state == IDLE) && !r_done && !r_overflow;
    assign w_accept   = IN_VALID && w_in_ready;

    sram_write_timer #(
        .WE_CYCLES (WE_CYCLES)
    ) u_timer (
        .CLK       (CLK),
        .RST       (RST),
        .i_load    (r_state == SETUP),
        .o_expired (w_pulse_done)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= IDLE;
            r_addr       <= BASE_ADDR;
            r_word_count <= '0;
            r_dq_out     <= 16'd0;
            r_last       <= 1'b0;
            r_dq_en      <= 1'b0;
            r_we         <= 1'b1;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_dq_out <= IN_DATA;
                        r_last   <= IN_LAST;
                        r_dq_en  <= 1'b1;
                        r_state  <= SETUP;
                    end
                end
                SETUP: begin
                    r_we    <= 1'b0;
                    r_state <= PULSE;
                end
                PULSE: begin
                    if (w_pulse_done) begin
                        r_we    <= 1'b1;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    r_word_count <= r_word_count + 1'b1;
                    r_dq_en      <= 1'b0;
                    r_dq_out     <= 16'd0;
                    // The top address is never incremented past, so it cannot wrap.
                    if (r_addr != c_ADDR_MAX) begin
                        r_addr <= r_addr + 1'b1;
                    end
                    if (r_last) begin
                        r_done  <= 1'b1;
                        r_state <= FINISHED;
                    end else if (r_addr == c_ADDR_MAX) begin
                        r_overflow <= 1'b1;
                        r_state    <= FINISHED;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                FINISHED: begin
                    r_state <= FINISHED;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign IN_READY    = w_in_ready;
    assign SRAM_A      = r_addr;
    assign SRAM_DQ_OUT = r_dq_out;
    assign SRAM_DQ_EN  = r_dq_en;
    assign SRAM_WE     = r_we;
    assign SRAM_OE     = r_dq_en;
    assign SRAM_CE     = 1'b0;
    assign SRAM_LB     = 1'b0;
    assign SRAM_UB     = 1'b0;
    assign BUSY        = r_dq_en;
    assign DONE        = r_done;
    assign OVERFLOW    = r_overflow;
    assign WORD_COUNT  = r_word_count;

endmodule
`default_nettype wire

// File: doc/sram_loader.md
SRAM_LOADER -- requirements
Module: sram_loader

Interface
REQ-001 Parameter BASE_ADDR, default 0: first SRAM word address written after reset or restart.
REQ-002 Parameter WE_CYCLES, default 2: number of cycles SRAM_WE is held low per write; legal range 1..15.
REQ-003 CLK  input  1  50 MHz system clock; all logic on the rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 IN_VALID  input  1  IN_DATA/IN_LAST hold a valid instruction word.
REQ-006 IN_READY  output  1  loader will accept a word this cycle.
REQ-007 IN_DATA  input  16  instruction word (note[3:0], octave[5:4], rest reserved).
REQ-008 IN_LAST  input  1  marks the final word of the program.
REQ-009 SRAM_A  output  18  write address.
REQ-010 SRAM_DQ_OUT  output  16  write data; the tristate buffer lives at top level.
REQ-011 SRAM_DQ_EN  output  1  high while the loader drives the data bus.
REQ-012 SRAM_WE, SRAM_CE, SRAM_OE, SRAM_LB, SRAM_UB  output  1 each  active-low SRAM controls.
REQ-013 BUSY  output  1  a write is in progress.
REQ-014 DONE  output  1  program fully written; sticky until RST.
REQ-015 OVERFLOW  output  1  address space exhausted; sticky until RST.
REQ-016 WORD_COUNT  output  18  number of words written since reset.

Function
REQ-017 The FSM SHALL have states IDLE, SETUP, PULSE, HOLD and FINISHED.
REQ-018 IN_READY SHALL be 1 only in IDLE with DONE=0 and OVERFLOW=0.
REQ-019 A word SHALL be accepted on a clock edge where IN_VALID=1 and IN_READY=1; IN_DATA and IN_LAST are captured at that edge.
REQ-020 On accept, IDLE SHALL go to SETUP for exactly 1 cycle: address and data driven, SRAM_DQ_EN=1, SRAM_WE=1.
REQ-021 PULSE SHALL last exactly WE_CYCLES cycles with SRAM_WE=0, and address and data held stable.
REQ-022 HOLD SHALL last exactly 1 cycle with SRAM_WE=1 and data still driven; WORD_COUNT increments on exit from HOLD.
REQ-023 On exit from HOLD, the FSM SHALL go to FINISHED if the captured IN_LAST=1, otherwise to IDLE; word period is WE_CYCLES+3 cycles.
REQ-024 The address SHALL start at BASE_ADDR and increment by 1 after each HOLD.
REQ-025 If the word just written was at address 18'h3FFFF and IN_LAST=0, the address SHALL NOT wrap: OVERFLOW sets and the FSM enters FINISHED.
REQ-026 FINISHED SHALL set DONE=1 when entered by IN_LAST, hold SRAM_WE=1 and SRAM_DQ_EN=0, and ignore IN_VALID.
REQ-027 In every state, SRAM_CE=0, SRAM_LB=0 and SRAM_UB=0.
REQ-028 SRAM_OE SHALL be 1 whenever SRAM_DQ_EN=1, and 0 otherwise.
REQ-029 SRAM_DQ_EN=1 exactly in SETUP, PULSE and HOLD; BUSY equals SRAM_DQ_EN.
REQ-030 IN_VALID dropping or IN_DATA changing during SETUP, PULSE or HOLD SHALL NOT affect the write in progress.
REQ-031 IN_LAST accepted together with the first word SHALL produce a one-word program: WORD_COUNT=1, then DONE.

Reset
REQ-032 While RST=1, on the next edge: state=IDLE, SRAM_A=BASE_ADDR, WORD_COUNT=0, DONE=0, OVERFLOW=0, SRAM_WE=1, SRAM_DQ_EN=0, SRAM_OE=0, SRAM_DQ_OUT=0.
REQ-033 RST asserted during PULSE SHALL raise SRAM_WE and release the bus at the next edge; the partial word is not counted.
REQ-034 RST has priority over all other inputs.

Structure
REQ-035 State encoding, the 18-bit address width and the instruction field positions (note, octave) SHALL live in a shared package used by both loader and player.
REQ-036 One sub-module, sram_write_timer, SHALL count the PULSE cycles: load WE_CYCLES, pulse expired.

Verification
REQ-037 Reset, then 3 words 16'h0001, 16'h0012, 16'h0023 (last on third), IN_VALID constant -> SRAM writes at addresses 0,1,2; each WE low pulse lasts 2 cycles; WORD_COUNT=3; DONE=1; IN_READY=0.
REQ-038 IN_VALID toggled randomly and IN_DATA changed during PULSE -> the written data equals the captured words, and no word is written twice or dropped.
REQ-039 BASE_ADDR=18'h3FFFE, 3 words with no last -> writes at 3FFFE and 3FFFF; OVERFLOW=1; third word not accepted; WORD_COUNT=2.
REQ-040 RST pulsed during the second word's PULSE -> SRAM_WE=1 next cycle; WORD_COUNT=0; a reload starts again at address 0.
REQ-041 WE_CYCLES=1, single word 16'h0035 with IN_LAST=1 -> WE low for 1 cycle; word period 4 cycles; DONE=1 and WORD_COUNT=1.
